// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, and multi-cycle mul/div hold with watchdog.
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 40,
    parameter int MD_CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_WriteAddr,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        ID_UsesRt,
    input  logic        ID_Jump,
    input  logic        EX_BranchTaken,
    input  logic        EX_MulDiv,
    input  logic        MulDiv_done,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Write,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic        MulDiv_start,
    output logic        MD_Error,
    output logic [31:0] Stall_Count
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [MD_CNT_W-1:0] WD_LAST = MD_CNT_W'(MD_MAX_CYCLES - 1);

    state_t              state, next_state;
    logic [MD_CNT_W-1:0] watchdog;
    logic                md_error;
    logic                load_use;
    logic                wd_expired;

    assign load_use = ID_EX_MemRead && (ID_EX_WriteAddr != 5'd0) &&
                      ((ID_EX_WriteAddr == rs) || (ID_UsesRt && (ID_EX_WriteAddr == rt)));
    assign wd_expired = (watchdog == WD_LAST);
    assign MD_Error   = md_error;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            watchdog <= '0;
            md_error <= 1'b0;
        end else begin
            state <= next_state;
            if (state == RUN)
                watchdog <= '0;
            else if (!MulDiv_done && !wd_expired)
                watchdog <= watchdog + 1'b1;
            if (state == MD_WAIT && !MulDiv_done && wd_expired)
                md_error <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (EX_MulDiv) next_state = MD_WAIT;
            MD_WAIT: if (MulDiv_done || wd_expired) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MulDiv_start = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (EX_MulDiv) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        MulDiv_start = 1'b1;
                    end else if (EX_BranchTaken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end else if (ID_Jump) begin
                        IF_ID_Flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    // Hold until the unit answers or the watchdog forces a release.
                    if (!MulDiv_done && !wd_expired) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Write  = 1'b0;
                        EX_MEM_Flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (!PC_Write && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign Stall_Count = stall_cnt;
`else
    assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table for RUN decisions plus
// hand-written mul/div, watchdog and reset sequences, checked through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic       mr;
        logic [4:0] wa;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       jp;
        logic       br;
        logic       md;
        logic       dn;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  exp;
        logic [7:0]  mask;
        logic        chk_sc;
        logic [31:0] sc;
        string       name;
    } sb_t;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush, MulDiv_start, MD_Error}
    localparam logic [7:0] DEF = 8'b1101_0000;
    localparam logic [7:0] BR  = 8'b1111_1000;
    localparam logic [7:0] LU  = 8'b0001_1000;
    localparam logic [7:0] JMP = 8'b1111_0000;
    localparam logic [7:0] MDS = 8'b0000_0110;
    localparam logic [7:0] MDH = 8'b0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_WriteAddr, rs, rt;
    logic        ID_UsesRt, ID_Jump, EX_BranchTaken, EX_MulDiv, MulDiv_done;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic        EX_MEM_Flush, MulDiv_start, MD_Error;
    logic [31:0] Stall_Count;

    int          n_checks = 0;
    int          n_errors = 0;
    sb_t         sb[$];
    logic [31:0] model_sc = '0;
    logic        model_err = 1'b0;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_WriteAddr (ID_EX_WriteAddr),
        .rs              (rs),
        .rt              (rt),
        .ID_UsesRt       (ID_UsesRt),
        .ID_Jump         (ID_Jump),
        .EX_BranchTaken  (EX_BranchTaken),
        .EX_MulDiv       (EX_MulDiv),
        .MulDiv_done     (MulDiv_done),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Write     (ID_EX_Write),
        .ID_EX_Flush     (ID_EX_Flush),
        .EX_MEM_Flush    (EX_MEM_Flush),
        .MulDiv_start    (MulDiv_start),
        .MD_Error        (MD_Error),
        .Stall_Count     (Stall_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic mr, input logic [4:0] wa, input logic [4:0] vrs,
                                input logic [4:0] vrt, input logic ur, input logic jp,
                                input logic br, input logic md, input logic dn,
                                input logic [7:0] exp);
        vec_t v;
        v.mr = mr; v.wa = wa; v.rs = vrs; v.rt = vrt; v.ur = ur;
        v.jp = jp; v.br = br; v.md = md; v.dn = dn; v.exp = exp;
        return v;
    endfunction

    // One cycle: drive after the edge, push the expectation, compare at the falling edge.
    task automatic apply(input logic rst, input vec_t v, input string name);
        sb_t item;
        sb_t got;
        @(posedge clk);
        #1;
        reset           = rst;
        ID_EX_MemRead   = v.mr;
        ID_EX_WriteAddr = v.wa;
        rs              = v.rs;
        rt              = v.rt;
        ID_UsesRt       = v.ur;
        ID_Jump         = v.jp;
        EX_BranchTaken  = v.br;
        EX_MulDiv       = v.md;
        MulDiv_done     = v.dn;
        item.exp    = v.exp | {7'd0, model_err};
        item.mask   = rst ? 8'hFE : 8'hFF;
        item.chk_sc = !rst;
        item.sc     = model_sc;
        item.name   = name;
        sb.push_back(item);
        @(negedge clk);
        got = sb.pop_front();
        check(got.name,
              {24'd0, {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                       EX_MEM_Flush, MulDiv_start, MD_Error} & got.mask},
              {24'd0, got.exp & got.mask});
        if (got.chk_sc)
            check({got.name, "_stall_cnt"}, Stall_Count, got.sc);
        if (rst) begin
            model_sc  = '0;
            model_err = 1'b0;
        end else begin
`ifdef STALL_PERF_CNT_EN
            if (!v.exp[7] && model_sc != 32'hFFFF_FFFF)
                model_sc = model_sc + 32'd1;
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t table_v[12];
        vec_t idle;
        vec_t v;
        logic [31:0] exp11;

        table_v[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);  // no event
        table_v[1]  = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, LU);   // load-use on rs
        table_v[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF);  // r0 never hazards
        table_v[3]  = mk(1, 7, 3, 7, 0, 0, 0, 0, 0, DEF);  // rt match, rt unused
        table_v[4]  = mk(1, 7, 3, 7, 1, 0, 0, 0, 0, LU);   // rt match, rt used
        table_v[5]  = mk(0, 5, 5, 0, 0, 0, 0, 0, 0, DEF);  // not a load
        table_v[6]  = mk(1, 5, 5, 0, 0, 0, 1, 0, 0, BR);   // branch beats load-use
        table_v[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, JMP);  // jump
        table_v[8]  = mk(1, 9, 9, 0, 0, 1, 0, 0, 0, LU);   // load-use beats jump
        table_v[9]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, BR);   // branch beats jump
        table_v[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);  // done ignored in RUN
        table_v[11] = mk(1, 9, 3, 4, 1, 0, 0, 0, 0, DEF);  // load, no match
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);

        apply(1'b1, idle, "reset_a");
        apply(1'b1, idle, "reset_b");
        apply(1'b0, idle, "after_reset");

        for (int i = 0; i < 12; i++)
            apply(1'b0, table_v[i], $sformatf("vec%0d", i));

        // Mul/div answered after 10 wait cycles; RUN events must be ignored while waiting.
        apply(1'b1, idle, "reset_md");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS), "md_start");
        for (int i = 0; i < 10; i++)
            apply(1'b0, mk(1, 5, 5, 0, 0, 1, 1, 1, 0, MDH), $sformatf("md_hold%0d", i));
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF), "md_done");
        apply(1'b0, idle, "md_after");
`ifdef STALL_PERF_CNT_EN
        exp11 = 32'd11;
`else
        exp11 = 32'd0;
`endif
        check("stall_count_md", Stall_Count, exp11);

        // Back-to-back multi-cycle ops each get their own start pulse.
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS), "b2b_start1");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDH), "b2b_hold1");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF), "b2b_done1");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS), "b2b_start2");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF), "b2b_done2");
        apply(1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, JMP), "b2b_run");

        // Watchdog: no done, release on the 40th wait cycle, sticky error afterwards.
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS), "wd_start");
        for (int i = 0; i < 39; i++)
            apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDH), $sformatf("wd_hold%0d", i));
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF), "wd_release");
        model_err = 1'b1;
        apply(1'b0, idle, "wd_err_run");
        apply(1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, JMP), "wd_err_jump");
        apply(1'b0, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, LU), "wd_err_lu");

        // Reset in the third wait cycle returns to RUN with everything cleared.
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS), "rst_md_start");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDH), "rst_md_hold0");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDH), "rst_md_hold1");
        apply(1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF), "rst_md_reset");
        apply(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF), "rst_md_run");
        check("rst_stall_count", Stall_Count, 32'd0);
        check("rst_md_error", {31'd0, MD_Error}, 32'd0);
        apply(1'b0, mk(1, 5, 5, 0, 0, 0, 0, 0, 0, LU), "rst_md_lu");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_MAX_CYCLES, default 40: watchdog limit in cycles spent in MD_WAIT.
REQ-002 Parameter MD_CNT_W, default 6: watchdog counter width; SHALL satisfy 2^MD_CNT_W > MD_MAX_CYCLES.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 ID_EX_MemRead  in  1  instruction in EX is a load.
REQ-006 ID_EX_WriteAddr  in  5  destination register of instruction in EX.
REQ-007 rs  in  5  rs field of instruction in ID.
REQ-008 rt  in  5  rt field of instruction in ID.
REQ-009 ID_UsesRt  in  1  instruction in ID reads rt as a source.
REQ-010 ID_Jump  in  1  jump decoded in ID.
REQ-011 EX_BranchTaken  in  1  branch in EX resolved taken.
REQ-012 EX_MulDiv  in  1  instruction in EX is a multi-cycle multiply/divide.
REQ-013 MulDiv_done  in  1  multi-cycle unit result valid.
REQ-014 PC_Write  out  1  PC update enable.
REQ-015 IF_ID_Write  out  1  IF/ID register enable.
REQ-016 IF_ID_Flush  out  1  IF/ID cleared to NOP.
REQ-017 ID_EX_Write  out  1  ID/EX register enable.
REQ-018 ID_EX_Flush  out  1  ID/EX cleared to bubble.
REQ-019 EX_MEM_Flush  out  1  EX/MEM loaded with bubble.
REQ-020 MulDiv_start  out  1  one-cycle start pulse to multi-cycle unit.
REQ-021 MD_Error  out  1  sticky watchdog-expired flag.
REQ-022 Stall_Count  out  32  cycles with PC_Write=0 (see Configuration).

Function
REQ-023 FSM states SHALL be RUN, MD_WAIT; control outputs are combinational from state and inputs.
REQ-024 Default outputs (RUN, no event): PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, all flushes 0, MulDiv_start=0.
REQ-025 Load-use hit = ID_EX_MemRead && ID_EX_WriteAddr!=0 && (ID_EX_WriteAddr==rs || (ID_UsesRt && ID_EX_WriteAddr==rt)).
REQ-026 RUN priority: EX_MulDiv > EX_BranchTaken > load-use > ID_Jump.
REQ-027 RUN, EX_MulDiv=1: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1, MulDiv_start=1; next state MD_WAIT, watchdog cleared to 0.
REQ-028 RUN, EX_BranchTaken=1: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; any concurrent load-use or jump ignored.
REQ-029 RUN, load-use hit: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 (exactly one bubble per hit).
REQ-030 RUN, ID_Jump=1: IF_ID_Flush=1 only.
REQ-031 MD_WAIT, MulDiv_done=0 and watchdog<MD_MAX_CYCLES-1: same hold outputs as REQ-027 except MulDiv_start=0; watchdog increments.
REQ-032 MD_WAIT, MulDiv_done=1: default outputs (EX/MEM captures result); next state RUN.
REQ-033 MD_WAIT, watchdog==MD_MAX_CYCLES-1 and MulDiv_done=0: release as REQ-032, MD_Error set to 1.
REQ-034 MulDiv_done SHALL be ignored in RUN; EX_BranchTaken, load-use and ID_Jump ignored in MD_WAIT.
REQ-035 Back-to-back multi-cycle ops: each SHALL produce its own MulDiv_start pulse and MD_WAIT episode.

Reset
REQ-036 reset=1 at a clock edge SHALL force state RUN, watchdog 0, MD_Error 0, Stall_Count 0, including mid-MD_WAIT.
REQ-037 While reset=1 outputs SHALL equal REQ-024 defaults with MulDiv_start=0.

Configuration
REQ-038 Macro STALL_PERF_CNT_EN defined: Stall_Count increments each non-reset cycle with PC_Write=0, saturating at 32'hFFFFFFFF.
REQ-039 Macro undefined: Stall_Count SHALL be tied to 0 and no counter logic synthesized; all other behaviour unchanged.

Verification
REQ-040 ID_EX_MemRead=1, ID_EX_WriteAddr=5, rs=5 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; ID_EX_WriteAddr=0, rs=0 -> no stall.
REQ-041 rt=7 matches, ID_UsesRt=0 -> no stall; ID_UsesRt=1 -> stall.
REQ-042 EX_BranchTaken=1 with simultaneous load-use hit -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
REQ-043 EX_MulDiv=1, MulDiv_done after 10 cycles -> MulDiv_start high exactly 1 cycle, stall held 11 cycles, release on done cycle, Stall_Count=11 (macro on).
REQ-044 MulDiv_done never asserted -> release after 40 MD_WAIT cycles, MD_Error=1 until reset.
REQ-045 reset asserted in 3rd MD_WAIT cycle -> next cycle state RUN, defaults, MD_Error=0, Stall_Count=0.
